// File: rtl/output_uart_pkg.sv
// output_uart_pkg
// Shared types, ASCII constants and the binary-to-decimal helpers for the
// output_uart transmitter.
//   state_t     : per-frame UART state (IDLE, START, DATA, STOP)
//   bin_to_dec  : 8-bit binary -> {hundreds[1:0], tens[3:0], ones[3:0]}
//   char_sel    : character of a message for a given value and index 0..4

package output_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Compare-subtract against 200/100, then 90 down to 10; the first tens
    // match wins, so the remainder is the ones digit.
    function automatic logic [9:0] bin_to_dec(input logic [7:0] bin);
        logic [7:0] rem;
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
        rem = bin;
        h   = 2'd0;
        t   = 4'd0;
        if (rem >= 8'd200) begin
            h   = 2'd2;
            rem = rem - 8'd200;
        end else if (rem >= 8'd100) begin
            h   = 2'd1;
            rem = rem - 8'd100;
        end
        for (int unsigned k = 9; k >= 1; k--) begin
            if (t == 4'd0 && rem >= 8'(k * 10)) begin
                t   = 4'(k);
                rem = rem - 8'(k * 10);
            end
        end
        o = 4'(rem);
        return {h, t, o};
    endfunction

    // Index 0..2 are the decimal digits, 3 is CR, 4 is LF.
    function automatic logic [7:0] char_sel(input logic [7:0] v, input logic [2:0] idx);
        logic [9:0] d;
        logic [7:0] c;
        d = bin_to_dec(v);
        case (idx)
            3'd0:    c = ASCII_ZERO + {6'd0, d[9:8]};
            3'd1:    c = ASCII_ZERO + {4'd0, d[7:4]};
            3'd2:    c = ASCII_ZERO + {4'd0, d[3:0]};
            3'd3:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/output_uart_if.sv
// output_uart_if
// CPU-side output bus plus the UART/LED outputs of output_uart.
//   cpu_clk_rise : one-clk strobe per rising edge of the CPU clock
//   out_en       : OUT instruction enable from control
//   bus          : CPU data bus
//   tx           : UART serial line, 8N1, idle high
//   busy         : a message is in progress
//   overrun      : sticky, a captured value was lost
//   value        : most recently captured byte (LEDs)
// modport master drives the CPU side; modport slave is the transmitter.

interface output_uart_if;

    logic       cpu_clk_rise;
    logic       out_en;
    logic [7:0] bus;
    logic       tx;
    logic       busy;
    logic       overrun;
    logic [7:0] value;

    modport master (
        output cpu_clk_rise,
        output out_en,
        output bus,
        input  tx,
        input  busy,
        input  overrun,
        input  value
    );

    modport slave (
        input  cpu_clk_rise,
        input  out_en,
        input  bus,
        output tx,
        output busy,
        output overrun,
        output value
    );

endinterface

// File: rtl/output_uart_tx_byte.sv
// uart_tx_byte
// Single 8N1 frame transmitter with back-to-back chaining.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : request a frame; accepted in IDLE or on the final stop cycle
//   data       : byte to send, sampled when start is accepted
//   done       : high on the last cycle of the stop bit
//   tx         : registered serial output, idle high
//   busy       : a frame is in progress

module uart_tx_byte
    import output_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    state_t            state, state_d;
    logic [BAUD_W-1:0] baud_cnt, baud_d;
    logic [2:0]        bit_cnt, bit_d;
    logic [7:0]        shreg, sh_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shreg    <= sh_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        baud_end = (baud_cnt == BAUD_LAST);
        state_d  = state;
        baud_d   = baud_cnt + BAUD_W'(1);
        bit_d    = bit_cnt;
        sh_d     = shreg;
        tx_d     = tx_q;
        done     = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (start) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    sh_d    = data;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                        sh_d  = {1'b0, shreg[7:1]};
                        tx_d  = shreg[1];
                    end
                end
            end
            default: begin // STOP
                if (baud_end) begin
                    done   = 1'b1;
                    baud_d = '0;
                    // A start on the last stop cycle chains the next frame
                    // with no idle gap.
                    if (start) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        sh_d    = data;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state != IDLE);

endmodule

// File: rtl/output_uart.sv
// output_uart
// Sends each byte written by the CPU OUT instruction as three ASCII decimal
// digits (optionally followed by CR LF) on a UART line, and shows the byte
// on the LEDs.
//   clk, rst_n : system clock, asynchronous active-low reset
//   io (slave) : cpu_clk_rise, out_en, bus in; tx, busy, overrun, value out
// Parameters: CLKS_PER_BIT (>= 2) clocks per bit, SEND_CRLF appends CR LF.

module output_uart
    import output_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int SEND_CRLF    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output_uart_if.slave  io
);

    localparam int unsigned NUM_CHARS = (SEND_CRLF != 0) ? 5 : 3;
    localparam logic [2:0]  LAST_IDX  = 3'(NUM_CHARS - 1);

    logic [7:0] work, work_d;
    logic [2:0] char_idx, idx_d;
    logic [7:0] pend, pend_d;
    logic       pend_v, pend_v_d;
    logic       launch, launch_d;
    logic       overrun_q, overrun_d;
    logic [7:0] value_q, value_d;

    logic       capture;
    logic       active;
    logic       last_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_busy;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (tx_data),
        .done  (tx_done),
        .tx    (io.tx),
        .busy  (tx_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            char_idx  <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            launch    <= 1'b0;
            overrun_q <= 1'b0;
            value_q   <= '0;
        end else begin
            work      <= work_d;
            char_idx  <= idx_d;
            pend      <= pend_d;
            pend_v    <= pend_v_d;
            launch    <= launch_d;
            overrun_q <= overrun_d;
            value_q   <= value_d;
        end
    end

    always_comb begin
        capture   = io.out_en && io.cpu_clk_rise;
        // launch covers the cycle between an idle capture and the first
        // start bit, so a capture there is queued rather than restarting.
        active    = launch || tx_busy;
        last_done = tx_done && (char_idx == LAST_IDX);

        tx_start  = 1'b0;
        tx_data   = char_sel(work, char_idx);
        work_d    = work;
        idx_d     = char_idx;
        pend_d    = pend;
        pend_v_d  = pend_v;
        launch_d  = 1'b0;
        overrun_d = overrun_q;
        value_d   = capture ? io.bus : value_q;

        // Frame sequencing: first frame, next character, or next message.
        if (launch) begin
            tx_start = 1'b1;
            tx_data  = char_sel(work, 3'd0);
        end else if (tx_done && !last_done) begin
            tx_start = 1'b1;
            idx_d    = char_idx + 3'd1;
            tx_data  = char_sel(work, idx_d);
        end else if (last_done) begin
            if (pend_v) begin
                tx_start = 1'b1;
                work_d   = pend;
                idx_d    = 3'd0;
                pend_v_d = 1'b0;
                tx_data  = char_sel(pend, 3'd0);
            end else if (capture) begin
                tx_start = 1'b1;
                work_d   = io.bus;
                idx_d    = 3'd0;
                tx_data  = char_sel(io.bus, 3'd0);
            end
        end

        // Capture routing. On the final stop cycle the pending slot is being
        // drained, so a capture there refills it without an overrun.
        if (capture) begin
            if (!active) begin
                work_d   = io.bus;
                idx_d    = 3'd0;
                launch_d = 1'b1;
            end else if (!(last_done && !pend_v)) begin
                if (pend_v && !last_done) begin
                    overrun_d = 1'b1;
                end
                pend_d   = io.bus;
                pend_v_d = 1'b1;
            end
        end
    end

    assign io.busy    = tx_busy;
    assign io.overrun = overrun_q;
    assign io.value   = value_q;

endmodule

// File: tb/tb_output_uart.sv
// tb_output_uart
// Scoreboard bench for output_uart with CLKS_PER_BIT=4. Instance a sends
// CR LF, instance b does not. Expected characters are queued when a capture
// is issued; per-instance UART decoders pop and compare each received frame.

module tb_output_uart;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_uart_if if_a();
    output_uart_if if_b();

    output_uart #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if_a)
    );

    output_uart #(.CLKS_PER_BIT(CPB), .SEND_CRLF(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if_b)
    );

    int tests = 0;
    int fails = 0;
    byte unsigned exp_a[$];
    byte unsigned exp_b[$];
    int runs_a[$];
    int runs_b[$];
    int run_a = 0;
    int run_b = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_tx(input int id);
        return (id == 0) ? if_a.tx : if_b.tx;
    endfunction

    function automatic logic get_busy(input int id);
        return (id == 0) ? if_a.busy : if_b.busy;
    endfunction

    // Frame decoder: start detected at offset 0, data bit b sampled at
    // offset CPB*(b+1)+CPB/2, stop at CPB*9+CPB/2.
    task automatic mon_frames(input int id);
        logic [7:0] d;
        logic       stop_bit;
        logic       aborted;
        byte unsigned e;
        forever begin
            @(negedge clk);
            if (rst_n && get_tx(id) == 1'b0) begin
                aborted  = 1'b0;
                d        = '0;
                stop_bit = 1'b0;
                for (int k = 1; k <= CPB * 9 + CPB / 2; k++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    if (k >= CPB + CPB / 2 && k <= CPB * 8 + CPB / 2 && ((k - CPB / 2) % CPB) == 0)
                        d[(k - CPB / 2) / CPB - 1] = get_tx(id);
                end
                stop_bit = get_tx(id);
                if (!aborted) begin
                    if ((id == 0 && exp_a.size() == 0) || (id == 1 && exp_b.size() == 0)) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame[%0d]: got 0x%0h expected none at %0t", id, d, $time);
                    end else begin
                        e = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
                        check($sformatf("frame_byte[%0d]", id), int'(d), int'(e));
                        check($sformatf("stop_bit[%0d]", id), int'(stop_bit), 1);
                    end
                end
            end
        end
    endtask

    initial mon_frames(0);
    initial mon_frames(1);

    // Length of each busy-high run, discarded when reset interrupts it.
    always @(negedge clk) begin
        if (!rst_n) run_a = 0;
        else if (if_a.busy) run_a++;
        else if (run_a != 0) begin runs_a.push_back(run_a); run_a = 0; end
        if (!rst_n) run_b = 0;
        else if (if_b.busy) run_b++;
        else if (run_b != 0) begin runs_b.push_back(run_b); run_b = 0; end
    end

    task automatic push_str(input int id, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (id == 0) exp_a.push_back(s[i]);
            else         exp_b.push_back(s[i]);
        end
    endtask

    // Called at posedge+1; the inputs are sampled at the next posedge.
    task automatic capture(input int id, input logic [7:0] v);
        if (id == 0) begin
            if_a.out_en = 1'b1; if_a.cpu_clk_rise = 1'b1; if_a.bus = v;
        end else begin
            if_b.out_en = 1'b1; if_b.cpu_clk_rise = 1'b1; if_b.bus = v;
        end
        @(posedge clk);
        #1;
        if_a.out_en = 1'b0; if_a.cpu_clk_rise = 1'b0; if_a.bus = 8'h00;
        if_b.out_en = 1'b0; if_b.cpu_clk_rise = 1'b0; if_b.bus = 8'h00;
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (get_busy(id) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout[%0d]: got busy expected idle", id);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input int id, input int exp);
        if (id == 0) begin
            check("busy_run_count_a", runs_a.size(), 1);
            if (runs_a.size() > 0) check("busy_run_len_a", runs_a.pop_front(), exp);
        end else begin
            check("busy_run_count_b", runs_b.size(), 1);
            if (runs_b.size() > 0) check("busy_run_len_b", runs_b.pop_front(), exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "watchdog");
    end

    logic [7:0] bvals [3];
    string      bstrs [3];
    int         lows;

    initial begin
        if_a.out_en = 1'b0; if_a.cpu_clk_rise = 1'b0; if_a.bus = 8'h00;
        if_b.out_en = 1'b0; if_b.cpu_clk_rise = 1'b0; if_b.bus = 8'h00;
        bvals[0] = 8'h00; bstrs[0] = "000\r\n";
        bvals[1] = 8'hFF; bstrs[1] = "255\r\n";
        bvals[2] = 8'h64; bstrs[2] = "100\r\n";

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", int'(if_a.tx), 1);
        check("reset_busy", int'(if_a.busy), 0);
        check("reset_overrun", int'(if_a.overrun), 0);
        check("reset_value", int'(if_a.value), 8'h00);
        check("reset_tx_b", int'(if_b.tx), 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic message and start latency
        push_str(0, "123\r\n");
        capture(0, 8'h7B);
        check("value_7b", int'(if_a.value), 8'h7B);
        @(negedge clk);
        check("latency_busy_pre", int'(if_a.busy), 0);
        check("latency_tx_pre", int'(if_a.tx), 1);
        @(negedge clk);
        check("latency_busy", int'(if_a.busy), 1);
        check("latency_tx", int'(if_a.tx), 0);
        wait_idle(0);
        check_run(0, 200);

        // Boundary values
        for (int i = 0; i < 3; i++) begin
            push_str(0, bstrs[i]);
            capture(0, bvals[i]);
            wait_idle(0);
            check_run(0, 200);
        end
        check("value_64", int'(if_a.value), 8'h64);

        // Buffering and overrun
        push_str(0, "001\r\n003\r\n");
        capture(0, 8'h01);
        @(posedge clk); #1;
        capture(0, 8'h02);
        @(posedge clk); #1;
        check("overrun_clear_before", int'(if_a.overrun), 0);
        capture(0, 8'h03);
        check("overrun_set", int'(if_a.overrun), 1);
        check("value_03", int'(if_a.value), 8'h03);
        wait_idle(0);
        check_run(0, 400);
        check("overrun_sticky", int'(if_a.overrun), 1);

        // Reset during DATA of the second character
        push_str(0, "1");
        capture(0, 8'h7B);
        repeat (58) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", int'(if_a.tx), 1);
        check("midrst_busy", int'(if_a.busy), 0);
        check("midrst_value", int'(if_a.value), 8'h00);
        check("midrst_overrun", int'(if_a.overrun), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!if_a.tx || if_a.busy) lows++;
        end
        check("post_reset_quiet", lows, 0);
        check("post_reset_no_run", runs_a.size(), 0);
        check("post_reset_sb_empty", exp_a.size(), 0);
        @(posedge clk); #1;

        // Capture on the final stop-bit cycle
        push_str(0, "009\r\n047\r\n");
        capture(0, 8'h09);
        repeat (200) @(posedge clk);
        #1;
        capture(0, 8'h2F);
        check("chain_busy", int'(if_a.busy), 1);
        check("chain_overrun", int'(if_a.overrun), 0);
        wait_idle(0);
        check_run(0, 400);
        check("chain_overrun_end", int'(if_a.overrun), 0);
        check("chain_value", int'(if_a.value), 8'h2F);

        // Digits only
        push_str(1, "042");
        capture(1, 8'h2A);
        check("value_b", int'(if_b.value), 8'h2A);
        wait_idle(1);
        check_run(1, 120);

        repeat (50) @(posedge clk);
        #1;
        check("sb_empty_a", exp_a.size(), 0);
        check("sb_empty_b", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
